// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops, plus iterative MUL/DIVU/REMU
// (shift-add and restoring division, one bit per cycle) when ALU_MULDIV_EN is defined.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] ALU_in_X,
  input  logic [WIDTH-1:0] ALU_in_Y,
  output logic [WIDTH-1:0] ALU_out_S,
  output logic             ZR,
  output logic             busy,
  output logic             done
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [WIDTH-1:0] res_q, res_d;
  logic             zr_q, zr_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] single_res;
  logic [ShW-1:0]   shamt;

  assign shamt = ALU_in_Y[ShW-1:0];

  always_comb begin
    single_res = '0;
    case (operation)
      4'b0000: single_res = ALU_in_X & ALU_in_Y;
      4'b0001: single_res = ALU_in_X | ALU_in_Y;
      4'b0010: single_res = ALU_in_X + ALU_in_Y;
      4'b0011: single_res = ALU_in_X ^ ALU_in_Y;
      4'b0100: single_res = ALU_in_X << shamt;
      4'b0101: single_res = ALU_in_X >> shamt;
      4'b0110: single_res = ALU_in_X - ALU_in_Y;
      4'b0111: single_res = {{(WIDTH-1){1'b0}}, $signed(ALU_in_X) < $signed(ALU_in_Y)};
      4'b1000: single_res = {{(WIDTH-1){1'b0}}, ALU_in_X < ALU_in_Y};
      4'b1100: single_res = ~(ALU_in_X | ALU_in_Y);
      4'b1101: single_res = WIDTH'($signed(ALU_in_X) >>> shamt);
      default: single_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StIter} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // MUL: acc = partial product, a = shifted multiplicand, b = shifted multiplier.
  // DIV: acc = partial remainder, a = dividend shifting into quotient, b = divisor.
  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic             is_mul_q, is_mul_d, is_rem_q, is_rem_d;
  logic             is_iter;
  logic [WIDTH:0]   div_tmp;

  assign is_iter = (operation == 4'b1001) || (operation == 4'b1010) || (operation == 4'b1011);
  assign busy    = (state_q == StIter);

  always_comb begin
    res_d    = res_q;
    zr_d     = zr_q;
    done_d   = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    is_mul_d = is_mul_q;
    is_rem_d = is_rem_q;
    div_tmp  = {acc_q, a_q[WIDTH-1]};
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_iter) begin
            state_d  = StIter;
            cnt_d    = CntW'(WIDTH);
            acc_d    = '0;
            a_d      = ALU_in_X;
            b_d      = ALU_in_Y;
            is_mul_d = (operation == 4'b1001);
            is_rem_d = (operation == 4'b1011);
          end else begin
            res_d  = single_res;
            zr_d   = (single_res == '0);
            done_d = 1'b1;
          end
        end
      end
      StIter: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (is_mul_q) begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
          end else if (div_tmp >= {1'b0, b_q}) begin
            // A zero divisor always subtracts: quotient all-ones, remainder ends as X.
            acc_d = div_tmp[WIDTH-1:0] - b_q;
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_tmp[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d = StIdle;
          res_d   = (is_mul_q || is_rem_q) ? acc_q : a_q;
          zr_d    = (((is_mul_q || is_rem_q) ? acc_q : a_q) == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_mul_q <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_mul_q <= is_mul_d;
      is_rem_q <= is_rem_d;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    res_d  = res_q;
    zr_d   = zr_q;
    done_d = 1'b0;
    if (start) begin
      res_d  = single_res;
      zr_d   = (single_res == '0);
      done_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q  <= '0;
      zr_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      zr_q   <= zr_d;
      done_q <= done_d;
    end
  end

  assign ALU_out_S = res_q;
  assign ZR        = zr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle; MUL/DIVU/REMU sections follow ALU_MULDIV_EN.
module tb_alu_multicycle;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] ALU_in_X, ALU_in_Y, ALU_out_S;
  logic             ZR, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .operation(operation),
    .ALU_in_X (ALU_in_X),
    .ALU_in_Y (ALU_in_Y),
    .ALU_out_S(ALU_out_S),
    .ZR       (ZR),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_iter_op(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
    return (op == 4'b1001) || (op == 4'b1010) || (op == 4'b1011);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] model(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [4:0] sh;
    sh = y[4:0];
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0011: return x ^ y;
      4'b0100: return x << sh;
      4'b0101: return x >> sh;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: return (x < y) ? 32'd1 : 32'd0;
      4'b1100: return ~(x | y);
      4'b1101: return $signed(x) >>> sh;
`ifdef ALU_MULDIV_EN
      4'b1001: return x * y;
      4'b1010: return (y == 0) ? '1 : x / y;
      4'b1011: return (y == 0) ? x : x % y;
`endif
      default: return '0;
    endcase
  endfunction

  // Issues one op (drives at #1 after an edge), optionally pokes a second start at cycle
  // 'poke' of an iterative op, then waits for done and scores result, ZR, latency and busy.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] exp, input int poke);
    int lat;
    bit saw_busy;
    logic [WIDTH-1:0] e;
    operation = op;
    ALU_in_X  = x;
    ALU_in_Y  = y;
    start     = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start     = 1'b0;
    ALU_in_X  = $urandom;
    ALU_in_Y  = $urandom;
    operation = 4'($urandom_range(0, 15));
    lat       = 1;
    saw_busy  = 1'b0;
    while (!done && lat < 100) begin
      saw_busy |= busy;
      start = (lat == poke);
      if (lat == poke) begin
        operation = 4'b0010;
        ALU_in_X  = 32'd1;
        ALU_in_Y  = 32'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    check_eq({tag, "_done"}, done, 1'b1);
    e = exp_q.pop_front();
    check_eq({tag, "_res"}, ALU_out_S, e);
    check_eq({tag, "_zr"}, ZR, (e == '0));
    check_eq({tag, "_lat"}, lat, is_iter_op(op) ? WIDTH + 1 : 1);
    check_eq({tag, "_busy"}, saw_busy, is_iter_op(op));
    check_eq({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  // Idle for n cycles: done must stay low and the result must hold.
  task automatic hold_check(input string tag, input int n, input logic [WIDTH-1:0] exp);
    bit saw_done;
    saw_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    check_eq({tag, "_no_done"}, saw_done, 1'b0);
    check_eq({tag, "_held"}, ALU_out_S, exp);
    check_eq({tag, "_held_zr"}, ZR, (exp == '0));
  endtask

  initial begin
    logic [3:0] rop;
    logic [WIDTH-1:0] rx, ry;
    rst_n     = 1'b0;
    start     = 1'b0;
    operation = '0;
    ALU_in_X  = '0;
    ALU_in_Y  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_res", ALU_out_S, 0);
    check_eq("rst_zr", ZR, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add", 4'b0010, 32'd2565, 32'd1560, 32'd4125, -1);
    // Back-to-back: these issue in the cycle done is high.
    run_op("sub", 4'b0110, 32'd2565, 32'd3560, 32'hFFFF_FC1D, -1);
    run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, -1);
    run_op("sltu", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, -1);
    run_op("sra", 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, -1);
    run_op("sll_hi", 4'b0100, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, -1);
    run_op("srl", 4'b0101, 32'h8000_0000, 32'd31, 32'd1, -1);
    run_op("nor", 4'b1100, 32'h0F0F_0000, 32'h00F0_00FF, 32'hF000_FF00, -1);
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, -1);
    run_op("unused_e", 4'b1110, 32'd7, 32'd9, 32'd0, -1);
    run_op("unused_f", 4'b1111, 32'd7, 32'd9, 32'd0, -1);
    run_op("xor", 4'b0011, 32'hA5A5_5A5A, 32'hFFFF_0000, 32'h5A5A_5A5A, -1);
    hold_check("hold1", 3, 32'h5A5A_5A5A);

`ifdef ALU_MULDIV_EN
    run_op("mul", 4'b1001, 32'd1000, 32'd3000, 32'd3000000, 5);
    hold_check("mul_poke", 4, 32'd3000000);
    run_op("divu", 4'b1010, 32'd100, 32'd7, 32'd14, -1);
    run_op("remu", 4'b1011, 32'd100, 32'd7, 32'd2, -1);
    run_op("divu0", 4'b1010, 32'd5, 32'd0, 32'hFFFF_FFFF, -1);
    run_op("remu0", 4'b1011, 32'd5, 32'd0, 32'd5, -1);
    run_op("add_after_it", 4'b0010, 32'd10, 32'd20, 32'd30, -1);

    // Reset ten cycles into a DIVU: abort with no done pulse.
    operation = 4'b1010;
    ALU_in_X  = 32'd100;
    ALU_in_Y  = 32'd7;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("divrst_busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("divrst_busy", busy, 0);
    check_eq("divrst_res", ALU_out_S, 0);
    check_eq("divrst_zr", ZR, 1);
    hold_check("divrst", 40, 32'd0);
    run_op("add_after_rst", 4'b0010, 32'd1, 32'd1, 32'd2, -1);
`else
    run_op("mul_off", 4'b1001, 32'd3, 32'd4, 32'd0, -1);
    run_op("divu_off", 4'b1010, 32'd100, 32'd7, 32'd0, -1);
    run_op("remu_off", 4'b1011, 32'd100, 32'd7, 32'd0, -1);
`endif

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = $urandom;
      ry  = $urandom;
      if (i % 4 == 0) ry = 32'($urandom_range(0, 9));
      run_op("rand", rop, rx, ry, model(rop, rx, ry), -1);
    end
    hold_check("hold2", 2, ALU_out_S === model(rop, rx, ry) ? ALU_out_S : model(rop, rx, ry));

    // Start asserted during reset is dropped.
    run_op("pre_rst", 4'b0001, 32'h10, 32'h01, 32'h11, -1);
    rst_n     = 1'b0;
    start     = 1'b1;
    operation = 4'b0010;
    ALU_in_X  = 32'd5;
    ALU_in_Y  = 32'd5;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    check_eq("rst_start_done", done, 0);
    check_eq("rst_start_res", ALU_out_S, 0);
    check_eq("rst_start_zr", ZR, 1);
    hold_check("rst_start", 2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
